sim_halt_monitor: RTL and testbench
===================================

Name: sim_halt_monitor

Overview:
Parametrised end-of-run detector for the simulation top. Watches the processing-unit state and N peripheral-activity channels. Declares a registered, optionally sticky "machine stopped" once the PU has sat in its idle state for a programmable number of cycles with all channels quiet. Also records the stop cycle and stop count, and provides an optional run-away watchdog so the bench can end cleanly on both halt and hang.

Parameters:
STATE_W, 3, width of pu_state
IDLE_STATE, 0, pu_state encoding treated as stopped
CHANNELS, 2, number of activity channels (input, output, ...)
IDLE_W, 8, idle counter width
IDLE_CYCLES, 255, idle cycles required; legal range 1..2^IDLE_W-1
CYCLE_W, 32, free-running cycle counter width
STICKY, 0, 1 = stop flag held until clear_stop
TIMEOUT_CYCLES, 1000000, watchdog limit in cycles; 0 disables

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pu_state  in  STATE_W  current PU state
chan_active  in  CHANNELS  per-channel busy flags
clear_stop  in  1  one-cycle pulse; releases a sticky stop
machine_is_stop  out  1  registered stop indication
watchdog_timeout  out  1  sticky hang indication
stop_cycle  out  CYCLE_W  cycle_cnt value latched at last stop entry
stop_count  out  8  number of RUN->STOPPED entries, saturating at 255
idle_count  out  IDLE_W  current idle counter

Behaviour:
- Reset (sync, high): FSM=RUN. cycle_cnt, idle_count, stop_cycle, stop_count = 0. machine_is_stop = 0, watchdog_timeout = 0.
- cycle_cnt: +1 every non-reset cycle; saturates at all-ones.
- idle_count (every state):
  - pu_state != IDLE_STATE -> 0.
  - pu_state == IDLE_STATE and idle_count < IDLE_CYCLES -> +1.
  - Otherwise hold.
  - Channel activity does not clear it.
- stop_cond = (idle_count == IDLE_CYCLES) && (chan_active == 0), evaluated on current register values.
- FSM states: RUN, STOPPED, TIMEOUT.
  - RUN -> STOPPED when stop_cond:
    - machine_is_stop = 1 on the next edge (1-cycle latency from stop_cond).
    - stop_cycle <= cycle_cnt.
    - stop_count +1, saturating.
  - RUN -> TIMEOUT when TIMEOUT_CYCLES != 0 && cycle_cnt == TIMEOUT_CYCLES-1 && !stop_cond. Sets watchdog_timeout = 1.
  - Stop and timeout conditions true in the same cycle: stop wins.
  - STOPPED, STICKY = 0: -> RUN when pu_state != IDLE_STATE or any chan_active; machine_is_stop drops on the same edge.
  - STOPPED, STICKY = 1: stay until clear_stop. Then -> RUN, machine_is_stop = 0; re-entry requires stop_cond again.
  - clear_stop outside STOPPED: ignored.
  - TIMEOUT is absorbing until reset. machine_is_stop stays 0. idle_count still updates.
- The watchdog is evaluated only in RUN. Cycles spent in STOPPED still advance cycle_cnt.
- Reset mid-stop or mid-timeout returns all outputs to reset values on the next edge.

Optional Feature:
SIM_HALT_MONITOR_WATCHDOG_EN
- Defined: TIMEOUT state and watchdog_timeout logic are present as above.
- Undefined: no TIMEOUT state; watchdog_timeout tied to 0; TIMEOUT_CYCLES ignored; all other behaviour unchanged.

Decomposition:
- Package sim_pkg holds:
  - FSM state enum (RUN=2'd0, STOPPED=2'd1, TIMEOUT=2'd2).
  - STOP_COUNT_W=8 constant.
- Natural sub-module: sim_sat_counter (width param, inc/clear/limit, saturating). Instantiated for idle_count, cycle_cnt and stop_count.
- The FSM stays in sim_halt_monitor.

Test Plan:
- Defaults; after reset, pu_state=0, chan_active=0 held -> idle_count reaches 255 at cycle 255, machine_is_stop=1 one cycle later, stop_cycle=255, stop_count=1.
- Defaults; pu_state=0 but chan_active=2'b10 held 300 cycles -> idle_count saturates at 255, machine_is_stop=0. Drop chan_active -> stop asserts on the next edge.
- STICKY=0; in STOPPED drive pu_state=3 for one cycle -> machine_is_stop falls on that edge, idle_count=0. Return to 0 -> stop re-asserts after 256 cycles, stop_count=2.
- STICKY=1; in STOPPED drive pu_state=3 -> stop stays 1. Pulse clear_stop -> stop falls next edge. Re-stop requires idle_count to refill to IDLE_CYCLES.
- WATCHDOG_EN, TIMEOUT_CYCLES=100; pu_state toggles 1/2 continuously -> watchdog_timeout=1 after the edge at cycle 99 and remains 1 for 50 further cycles with pu_state=0.
- Assert reset while machine_is_stop=1 and stop_count=3 -> next edge: all outputs 0, FSM=RUN.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared types for the simulation halt monitor: FSM state encoding and stop-counter width.
package sim_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STOPPED = 2'd1,
      TIMEOUT = 2'd2
   } sim_state_e;

   localparam int STOP_COUNT_W = 8;

endpackage

// File: rtl/sim_sat_counter.sv
// Purpose: up-counter that saturates at a run-time limit, with synchronous clear.
// Latency: count reflects clear/inc on the next clk edge.
// Backpressure: none; inc is simply ignored once the limit is reached.
module sim_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count < limit)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sim_halt_monitor.sv
// Purpose: flags end-of-run when the PU idles IDLE_CYCLES with all channels quiet; optional watchdog via SIM_HALT_MONITOR_WATCHDOG_EN.
// Latency: machine_is_stop / watchdog_timeout rise one clk edge after their condition is seen.
// Backpressure: none; pure observer of pu_state and chan_active.
module sim_halt_monitor
   import sim_pkg::*;
#(
   parameter int STATE_W        = 3,
   parameter int IDLE_STATE     = 0,
   parameter int CHANNELS       = 2,
   parameter int IDLE_W         = 8,
   parameter int IDLE_CYCLES    = 255,
   parameter int CYCLE_W        = 32,
   parameter int STICKY         = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [STATE_W-1:0]      pu_state,
   input  logic [CHANNELS-1:0]     chan_active,
   input  logic                    clear_stop,
   output logic                    machine_is_stop,
   output logic                    watchdog_timeout,
   output logic [CYCLE_W-1:0]      stop_cycle,
   output logic [STOP_COUNT_W-1:0] stop_count,
   output logic [IDLE_W-1:0]       idle_count
);

   localparam logic [STATE_W-1:0]      IDLE_CODE  = STATE_W'(IDLE_STATE);
   localparam logic [IDLE_W-1:0]       IDLE_LIMIT = IDLE_W'(IDLE_CYCLES);
   localparam logic [CYCLE_W-1:0]      CYCLE_MAX  = '1;
   localparam logic [STOP_COUNT_W-1:0] STOP_MAX   = '1;

   sim_state_e         state_q;
   sim_state_e         state_d;
   logic [CYCLE_W-1:0] cycle_cnt;
   logic               pu_idle;
   logic               stop_cond;
   logic               enter_stop;
   logic               timeout_hit;

   assign pu_idle   = (pu_state == IDLE_CODE);
   assign stop_cond = (idle_count == IDLE_LIMIT) && (chan_active == '0);

   // Idle count keeps running in every FSM state; only a non-idle PU clears it.
   sim_sat_counter #(.WIDTH(IDLE_W)) u_idle_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (!pu_idle),
      .inc   (1'b1),
      .limit (IDLE_LIMIT),
      .count (idle_count)
   );

   sim_sat_counter #(.WIDTH(CYCLE_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (1'b1),
      .limit (CYCLE_MAX),
      .count (cycle_cnt)
   );

   sim_sat_counter #(.WIDTH(STOP_COUNT_W)) u_stop_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (enter_stop),
      .limit (STOP_MAX),
      .count (stop_count)
   );

`ifdef SIM_HALT_MONITOR_WATCHDOG_EN
   localparam logic [CYCLE_W-1:0] TIMEOUT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CYCLE_W'(TIMEOUT_CYCLES - 1);

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST);
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_d    = state_q;
      enter_stop = 1'b0;
      case (state_q)
         RUN: begin
            // A stop seen on the watchdog's last cycle takes priority.
            if (stop_cond) begin
               state_d    = STOPPED;
               enter_stop = 1'b1;
            end else if (timeout_hit) begin
               state_d = TIMEOUT;
            end
         end
         STOPPED: begin
            if (STICKY != 0) begin
               if (clear_stop) begin
                  state_d = RUN;
               end
            end else if (!pu_idle || (chan_active != '0)) begin
               state_d = RUN;
            end
         end
`ifdef SIM_HALT_MONITOR_WATCHDOG_EN
         TIMEOUT: state_d = TIMEOUT;
`endif
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= RUN;
         machine_is_stop <= 1'b0;
         stop_cycle      <= '0;
      end else begin
         state_q         <= state_d;
         machine_is_stop <= (state_d == STOPPED);
         if (enter_stop) begin
            stop_cycle <= cycle_cnt;
         end
      end
   end

`ifdef SIM_HALT_MONITOR_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         watchdog_timeout <= 1'b0;
      end else begin
         watchdog_timeout <= (state_d == TIMEOUT);
      end
   end
`else
   assign watchdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench: two monitors (non-sticky default, sticky short-idle with watchdog) driven by directed and random
// stimulus; a reference model queues expected outputs per edge and a monitor process compares them.
module tb_sim_halt_monitor;

   localparam int A_IC = 255;
   localparam int B_IC = 6;
   localparam int B_TO = 100;
`ifdef SIM_HALT_MONITOR_WATCHDOG_EN
   localparam bit WDEN = 1'b1;
`else
   localparam bit WDEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] pu_state = '0;
   logic [1:0] chan_active = '0;
   logic       clear_stop = 1'b0;

   logic        a_stop, a_wdt, b_stop, b_wdt;
   logic [31:0] a_scyc, b_scyc;
   logic [7:0]  a_scnt, b_scnt, a_idle, b_idle;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sim_halt_monitor #(.IDLE_CYCLES(A_IC), .STICKY(0), .TIMEOUT_CYCLES(0)) dut_a (
      .clk(clk), .reset(reset), .pu_state(pu_state), .chan_active(chan_active),
      .clear_stop(clear_stop), .machine_is_stop(a_stop), .watchdog_timeout(a_wdt),
      .stop_cycle(a_scyc), .stop_count(a_scnt), .idle_count(a_idle)
   );

   sim_halt_monitor #(.IDLE_CYCLES(B_IC), .STICKY(1), .TIMEOUT_CYCLES(B_TO)) dut_b (
      .clk(clk), .reset(reset), .pu_state(pu_state), .chan_active(chan_active),
      .clear_stop(clear_stop), .machine_is_stop(b_stop), .watchdog_timeout(b_wdt),
      .stop_cycle(b_scyc), .stop_count(b_scnt), .idle_count(b_idle)
   );

   typedef struct {
      bit     stop;
      bit     wdt;
      longint scyc;
      int     scnt;
      int     idle;
   } obs_t;

   typedef struct {
      obs_t a;
      obs_t b;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state, index 0 = dut_a, 1 = dut_b.
   longint m_cyc[2];
   longint m_scyc[2];
   int     m_idle[2];
   int     m_scnt[2];
   bit     m_stopped[2];
   bit     m_tmo[2];
   int     m_ic[2]     = '{A_IC, B_IC};
   bit     m_sticky[2] = '{1'b0, 1'b1};
   int     m_to[2]     = '{0, B_TO};

   task automatic model_step(input int d, input bit rst, input int ps, input int ch, input bit clr);
      bit quiet_and_idle;
      bit wd_hit;
      if (rst) begin
         m_cyc[d] = 0; m_scyc[d] = 0; m_idle[d] = 0; m_scnt[d] = 0;
         m_stopped[d] = 0; m_tmo[d] = 0;
         return;
      end
      quiet_and_idle = (m_idle[d] == m_ic[d]) && (ch == 0);
      wd_hit = WDEN && (m_to[d] != 0) && (m_cyc[d] == longint'(m_to[d] - 1));
      if (m_tmo[d]) begin
         m_tmo[d] = 1;
      end else if (m_stopped[d]) begin
         if (m_sticky[d] ? clr : (ps != 0 || ch != 0)) m_stopped[d] = 0;
      end else if (quiet_and_idle) begin
         m_stopped[d] = 1;
         m_scyc[d] = m_cyc[d];
         m_scnt[d] = (m_scnt[d] < 255) ? m_scnt[d] + 1 : 255;
      end else if (wd_hit) begin
         m_tmo[d] = 1;
      end
      m_idle[d] = (ps != 0) ? 0 : ((m_idle[d] < m_ic[d]) ? m_idle[d] + 1 : m_idle[d]);
      m_cyc[d] = (m_cyc[d] < 64'hFFFF_FFFF) ? m_cyc[d] + 1 : m_cyc[d];
   endtask

   function automatic obs_t model_obs(input int d);
      obs_t o;
      o.stop = m_stopped[d];
      o.wdt  = m_tmo[d];
      o.scyc = m_scyc[d];
      o.scnt = m_scnt[d];
      o.idle = m_idle[d];
      return o;
   endfunction

   task automatic drive(input bit rst, input int ps, input int ch, input bit clr);
      exp_t e;
      @(negedge clk);
      reset       = rst;
      pu_state    = ps[2:0];
      chan_active = ch[1:0];
      clear_stop  = clr;
      for (int d = 0; d < 2; d++) model_step(d, rst, ps, ch, clr);
      e.a = model_obs(0);
      e.b = model_obs(1);
      sb_q.push_back(e);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("a.machine_is_stop", 64'(a_stop), 64'(e.a.stop));
            check("a.watchdog_timeout", 64'(a_wdt), 64'(e.a.wdt));
            check("a.stop_cycle", 64'(a_scyc), 64'(e.a.scyc));
            check("a.stop_count", 64'(a_scnt), 64'(e.a.scnt));
            check("a.idle_count", 64'(a_idle), 64'(e.a.idle));
            check("b.machine_is_stop", 64'(b_stop), 64'(e.b.stop));
            check("b.watchdog_timeout", 64'(b_wdt), 64'(e.b.wdt));
            check("b.stop_cycle", 64'(b_scyc), 64'(e.b.scyc));
            check("b.stop_count", 64'(b_scnt), 64'(e.b.scnt));
            check("b.idle_count", 64'(b_idle), 64'(e.b.idle));
         end
      end
   end

   initial begin
      int mode, len, ps, ch;
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      // Runaway PU: dut_b's watchdog fires at cycle 99 and must stay set.
      for (int i = 0; i < 120; i++) drive(0, (i % 2) ? 2 : 1, 0, 0);
      repeat (50) drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      // Clean halt: stop at cycle 255 for dut_a.
      repeat (260) drive(0, 0, 0, 0);
      drive(0, 3, 0, 0);
      repeat (260) drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      // Channel busy keeps idle saturated but blocks the stop.
      repeat (300) drive(0, 0, 2, 0);
      repeat (3) drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      repeat (4) drive(0, 0, 0, 0);
      for (int s = 0; s < 40; s++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0: begin
               len = $urandom_range(20, 300);
               repeat (len) drive(0, 0, 0, 0);
            end
            1: begin
               len = $urandom_range(5, 40);
               for (int i = 0; i < len; i++) begin
                  ps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
                  ch = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
                  drive(0, ps, ch, $urandom_range(0, 7) == 0);
               end
            end
            2: begin
               len = $urandom_range(5, 60);
               repeat (len) drive(0, 0, $urandom_range(1, 3), 0);
            end
            default: begin
               drive(0, 0, 0, 1);
               if ($urandom_range(0, 7) == 0) drive(1, 0, 0, 0);
            end
         endcase
      end
      // Reset while stopped.
      repeat (260) drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
